mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, requester count; LAT8, default 2, mode-0 result latency in cycles; LAT16, default 4, mode-1 latency; LAT32, default 8, mode-2 latency; QDEPTH, default 4, response FIFO depth.
REQ-002 clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  N_REQ  per-requester request valid.
REQ-005 req_ready  output  N_REQ  per-requester grant, combinational, at most one bit high.
REQ-006 req_a, req_b  input  16*N_REQ  per-requester signed operands; slice i is bits [16i+15:16i].
REQ-007 req_mode  input  2*N_REQ  per-requester precision: 0=Q0.3 to Q1.6, 1=Q0.7 to Q1.14, 2=Q0.15 to Q1.30, 3=illegal.
REQ-008 mul_a, mul_b  output  16  operands to the shared multiplier, registered.
REQ-009 mul_valid  output  1  issue strobe to the shared multiplier, registered.
REQ-010 mul_q8, mul_q16, mul_q32  input  8/16/32  multiplier result buses, one per precision.
REQ-011 rsp_valid, rsp_ready  output/input  1/1  response handshake.
REQ-012 rsp_id  output  clog2(N_REQ)  originating requester index.
REQ-013 rsp_mode  output  2  precision of the response.
REQ-014 rsp_data  output  32  result, sign-extended to 32 bits.
REQ-015 err  output  1  sticky flag, set on acceptance of a mode-3 request.
REQ-016 busy  output  1  high while any issue is in flight or the FIFO is non-empty.

Function
REQ-017 Arbitration SHALL be round-robin: the search starts at ptr, and ptr becomes grant+1 (mod N_REQ) after each transfer.
REQ-018 A request from i SHALL transfer in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-019 req_ready[i] SHALL be high only when all of the following hold: i wins the arbitration, the issue gate is open, credits are available, and the completion slot is free.
REQ-020 Issue gate: after a mode-0/1/2 issue, further issues SHALL be blocked for 0/1/3 subsequent cycles, giving an issue interval of 1/2/4.
REQ-021 Credits: a grant SHALL be given only if (in-flight issues + FIFO occupancy) < QDEPTH, so the FIFO never overflows.
REQ-022 Reservation table: the block SHALL keep a shift register LAT32 deep holding {valid, id, mode}; an issue of mode m SHALL require slot LAT_m to be empty and SHALL write it.
REQ-023 Two completions SHALL never fall in the same cycle.
REQ-024 On a transfer, mul_a, mul_b and mul_valid SHALL take the granted operands and 1 on the next edge; mul_valid SHALL otherwise be 0, and mul_a/mul_b SHALL hold their values.
REQ-025 Latency is counted from the cycle mul_valid is high: the result SHALL be sampled exactly LAT_m cycles later from the bus selected by mode, sign-extended, and pushed into the FIFO with id and mode.
REQ-026 The FIFO SHALL present its head on rsp_*; rsp_valid=!empty; a pop SHALL occur on rsp_valid&&rsp_ready; push and pop in the same cycle SHALL be allowed, including when full.
REQ-027 A mode-3 request SHALL be accepted (ready by the normal rules), not issued and consuming no credit, and SHALL set err; err SHALL be cleared only by reset.
REQ-028 Requester i SHALL hold its request stable until it transfers; responses SHALL leave in completion order, not issue order.

Reset
REQ-029 While rst_n=0, the block SHALL force: req_ready=0, mul_valid=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_mode=0, rsp_data=0, err=0, busy=0.
REQ-030 While rst_n=0, the block SHALL also force: ptr=0, gate open, reservation table cleared, FIFO empty.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and queued results; multiplier outputs arriving after reset SHALL be ignored.

Verification
REQ-032 Req0 mode 0, a=0x0003, b=0x000E -> mul_valid at T+1, rsp at T+1+LAT8+1: id 0, mode 0, rsp_data=sign-extended mul_q8 (0xFFFFFFFA when mul_q8=0xFA).
REQ-033 All 4 requesters mode 0, continuously valid -> grants in order 0,1,2,3,0, one per cycle, rsp_ready=1 throughout.
REQ-034 Req0 mode 2 at T, req1 mode 0 pending -> req1 not granted before T+4; no two completions in the same cycle.
REQ-035 rsp_ready=0 with 4 mode-0 issues -> 5th grant withheld until a pop; no response lost.
REQ-036 Req2 mode 3 -> ready pulse, err=1, no mul_valid, no response; rst_n pulse mid-stream -> all outputs 0, later mul_q* values never appear on rsp.

Source files
------------

// File: rtl/mul_sched.sv
// mul_sched: round-robin front end sharing one multi-precision multiplier among N_REQ requesters.
// A reservation table slots every issue so results complete one per cycle into a response FIFO.
module mul_sched #(
  parameter int N_REQ  = 4,
  parameter int LAT8   = 2,
  parameter int LAT16  = 4,
  parameter int LAT32  = 8,
  parameter int QDEPTH = 4,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [16*N_REQ-1:0] req_a,
  input  logic [16*N_REQ-1:0] req_b,
  input  logic [2*N_REQ-1:0]  req_mode,
  output logic [15:0]         mul_a,
  output logic [15:0]         mul_b,
  output logic                mul_valid,
  input  logic [7:0]          mul_q8,
  input  logic [15:0]         mul_q16,
  input  logic [31:0]         mul_q32,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [1:0]          rsp_mode,
  output logic [31:0]         rsp_data,
  output logic                err,
  output logic                busy
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1) + 1;
  localparam int LW = $clog2(LAT32 + 1);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
    logic [1:0]     mode;
  } slot_t;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [1:0]     gate_q, gate_d;
  logic [CW-1:0]  inflight_q, fcnt_q;
  logic [AW-1:0]  wr_q, rd_q;
  logic           err_q, mul_valid_q;
  logic [15:0]    mul_a_q, mul_b_q;
  slot_t          rt_q [LAT32+1];

  logic [IDW-1:0] fifo_id   [QDEPTH];
  logic [1:0]     fifo_mode [QDEPTH];
  logic [31:0]    fifo_data [QDEPTH];

  logic           found, slot_free, credit_ok, grant_ok;
  logic [IDW-1:0] win, idx;
  logic [1:0]     win_mode;
  logic [LW-1:0]  lat_sel;
  logic           xfer, issue, push, pop;
  logic [31:0]    cmp_data;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_mode = req_mode[2*win +: 2];

  always_comb begin
    case (win_mode)
      2'd1:    lat_sel = LW'(LAT16);
      2'd2:    lat_sel = LW'(LAT32);
      default: lat_sel = LW'(LAT8);
    endcase
    // An entry now one slot above the target would shift into it on this edge.
    slot_free = 1'b1;
    if (win_mode != 2'd3) begin
      for (int k = 1; k <= LAT32; k++) begin
        if (k == int'(lat_sel) + 1 && rt_q[k].v) slot_free = 1'b0;
      end
    end
  end

  assign rsp_valid = (fcnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = rt_q[0].v;
  // A pop on this edge frees its entry before any new result can land.
  assign credit_ok = (inflight_q + fcnt_q) < (CW'(QDEPTH) + CW'(pop));
  assign grant_ok  = rst_n && found && (gate_q == 2'd0) && credit_ok && slot_free;
  assign xfer      = grant_ok;
  assign issue     = xfer && (win_mode != 2'd3);
  assign ptr_d     = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = grant_ok && (win == IDW'(gi));
  end

  always_comb begin
    gate_d = (gate_q != 2'd0) ? gate_q - 2'd1 : 2'd0;
    if (issue) begin
      case (win_mode)
        2'd1:    gate_d = 2'd1;
        2'd2:    gate_d = 2'd3;
        default: gate_d = 2'd0;
      endcase
    end
  end

  always_comb begin
    case (rt_q[0].mode)
      2'd1:    cmp_data = {{16{mul_q16[15]}}, mul_q16};
      2'd2:    cmp_data = mul_q32;
      default: cmp_data = {{24{mul_q8[7]}}, mul_q8};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      gate_q      <= '0;
      inflight_q  <= '0;
      fcnt_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      for (int k = 0; k <= LAT32; k++) rt_q[k] <= '0;
    end else begin
      for (int k = 0; k < LAT32; k++) rt_q[k] <= rt_q[k+1];
      rt_q[LAT32] <= '0;
      if (issue) begin
        rt_q[lat_sel] <= {1'b1, win, win_mode};
        mul_a_q       <= req_a[16*win +: 16];
        mul_b_q       <= req_b[16*win +: 16];
      end
      mul_valid_q <= issue;
      gate_q      <= gate_d;
      if (xfer) ptr_q <= ptr_d;
      if (xfer && win_mode == 2'd3) err_q <= 1'b1;
      inflight_q <= inflight_q + CW'(issue) - CW'(push);
      fcnt_q     <= fcnt_q + CW'(push) - CW'(pop);
      if (push) wr_q <= (wr_q == AW'(QDEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == AW'(QDEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id[wr_q]   <= rt_q[0].id;
      fifo_mode[wr_q] <= rt_q[0].mode;
      fifo_data[wr_q] <= cmp_data;
    end
  end

  assign rsp_id    = rsp_valid ? fifo_id[rd_q]   : '0;
  assign rsp_mode  = rsp_valid ? fifo_mode[rd_q] : '0;
  assign rsp_data  = rsp_valid ? fifo_data[rd_q] : '0;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_valid = mul_valid_q;
  assign err       = err_q;
  assign busy      = (inflight_q != '0) || (fcnt_q != '0);
endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a completion-ordered scoreboard.
// Multiplier buses carry a cycle-indexed pattern so mis-timed sampling shows up as wrong data.
`timescale 1ns/1ps
module tb_mul_sched;
  localparam int N = 4, L8 = 2, L16 = 4, L32 = 8, QD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid, req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [2*N-1:0]  req_mode;
  logic [15:0]   mul_a, mul_b;
  logic          mul_valid;
  logic [7:0]    mul_q8;
  logic [15:0]   mul_q16;
  logic [31:0]   mul_q32;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id, rsp_mode;
  logic [31:0]   rsp_data;
  logic          err, busy;

  always #5 clk = ~clk;

  mul_sched #(.N_REQ(N), .LAT8(L8), .LAT16(L16), .LAT32(L32), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_q8(mul_q8), .mul_q16(mul_q16), .mul_q32(mul_q32),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_mode(rsp_mode), .rsp_data(rsp_data), .err(err), .busy(busy)
  );

  typedef struct {
    int          ccyc;
    logic [1:0]  id;
    logic [1:0]  mode;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   gcyc_log[$];
  int   errors = 0, checks = 0, cyc = 0;
  int   last_rsp_cyc = -1;
  logic [31:0] last_rsp_data = '0;
  logic pat_en = 1'b0, keep_valid = 1'b0, exp_mv = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_ab = '0;

  function automatic logic [55:0] raw(input int c);
    logic [7:0]  v8;
    logic [15:0] v16;
    logic [31:0] v32;
    v8  = pat_en ? 8'(c * 29 + 129) : 8'hFA;
    v16 = pat_en ? 16'(c * 1237 + 36611) : 16'h8001;
    v32 = pat_en ? ((32'(c) * 32'h9E3779B9) ^ 32'hA5A50F0F) : 32'h12345678;
    return {v32, v16, v8};
  endfunction

  function automatic logic [31:0] bus_val(input logic [1:0] m, input int c);
    logic [55:0] r;
    r = raw(c);
    case (m)
      2'd0:    return {{24{r[7]}}, r[7:0]};
      2'd1:    return {{16{r[23]}}, r[23:8]};
      default: return r[55:24];
    endcase
  endfunction

  task automatic set_buses();
    logic [55:0] r;
    r = raw(cyc);
    mul_q8  = r[7:0];
    mul_q16 = r[23:8];
    mul_q32 = r[55:24];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    set_buses();
  endtask

  task automatic step();
    logic [N-1:0] gnt;
    int           g;
    logic [1:0]   m;
    logic         nmv, nerr, collide, placed;
    logic [31:0]  nab;
    exp_t         e;
    int           pos;
    g = 0; nmv = 1'b0; nerr = 1'b0; nab = exp_ab; m = 2'd0;
    @(negedge clk);
    chk("mul_valid", 64'(mul_valid), 64'(exp_mv));
    if (exp_mv) chk("mul_ab", 64'({mul_a, mul_b}), 64'(exp_ab));
    chk("err", 64'(err), 64'(exp_err));
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
    if (rsp_valid && sb.size() == 0) begin
      chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
    end else if (rsp_valid && rsp_ready) begin
      e = sb.pop_front();
      chk("rsp", 64'({rsp_id, rsp_mode, rsp_data}), 64'({e.id, e.mode, e.data}));
      chk("rsp_not_early", 64'(cyc > e.ccyc), 64'd1);
      last_rsp_cyc  = cyc;
      last_rsp_data = rsp_data;
    end
    gnt = req_valid & req_ready;
    if (gnt != '0) begin
      for (int i = N - 1; i >= 0; i--) if (gnt[i]) g = i;
      m = req_mode[2*g +: 2];
      glog.push_back(g);
      gcyc_log.push_back(cyc);
      if (m == 2'd3) begin
        nerr = 1'b1;
      end else begin
        e.ccyc = cyc + 1 + ((m == 2'd0) ? L8 : (m == 2'd1) ? L16 : L32);
        e.id   = 2'(g);
        e.mode = m;
        e.data = bus_val(m, e.ccyc);
        collide = 1'b0;
        foreach (sb[k]) if (sb[k].ccyc == e.ccyc) collide = 1'b1;
        chk("one_completion_per_cycle", 64'(collide), 64'd0);
        pos = sb.size(); placed = 1'b0;
        foreach (sb[k]) if (!placed && sb[k].ccyc > e.ccyc) begin pos = k; placed = 1'b1; end
        sb.insert(pos, e);
        nmv = 1'b1;
        nab = {req_a[16*g +: 16], req_b[16*g +: 16]};
      end
    end
    tick();
    exp_mv = nmv;
    exp_ab = nab;
    if (nerr) exp_err = 1'b1;
    if (gnt != '0 && !keep_valid) req_valid[g] = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 60 && (sb.size() != 0 || req_valid != '0); t++) step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic arm(input int i, input logic [1:0] m);
    req_mode[2*i +: 2] = m;
    req_a[16*i +: 16]  = 16'($urandom);
    req_b[16*i +: 16]  = 16'($urandom);
    req_valid[i]       = 1'b1;
  endtask

  task automatic reset_outs(input string tag);
    chk(tag, 64'({req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_mode, err, busy}), 64'd0);
    chk({tag, "_data"}, 64'(rsp_data), 64'd0);
  endtask

  initial begin
    int g0;
    req_valid = '0; req_a = '0; req_b = '0; req_mode = '0; rsp_ready = 1'b1;
    set_buses();
    #1 rst_n = 1'b0;
    #1 reset_outs("reset_initial");
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Round robin with everyone continuously asking.
    keep_valid = 1'b1;
    for (int i = 0; i < N; i++) arm(i, 2'd0);
    glog.delete(); gcyc_log.delete();
    for (int t = 0; t < 10 && glog.size() < 5; t++) step();
    req_valid = '0; keep_valid = 1'b0;
    chk("rr_count", 64'(glog.size()), 64'd5);
    for (int k = 0; k < glog.size(); k++) chk($sformatf("rr_order%0d", k), 64'(glog[k]), 64'(k % N));
    for (int k = 1; k < gcyc_log.size(); k++)
      chk($sformatf("rr_gap%0d", k), 64'(gcyc_log[k] - gcyc_log[k-1]), 64'd1);
    drain("rr_drain");

    // Single mode-0 transaction with a negative 8-bit result.
    glog.delete(); gcyc_log.delete(); last_rsp_cyc = -1;
    req_mode[1:0] = 2'd0; req_a[15:0] = 16'h0003; req_b[15:0] = 16'h000E; req_valid[0] = 1'b1;
    for (int t = 0; t < 5 && glog.size() == 0; t++) step();
    drain("m0_drain");
    g0 = (gcyc_log.size() != 0) ? gcyc_log[0] : -100;
    chk("m0_rsp_cycle", 64'(last_rsp_cyc), 64'(g0 + L8 + 2));
    chk("m0_sext", 64'(last_rsp_data), 64'hFFFFFFFA);

    pat_en = 1'b1;
    set_buses();

    // Mode 2 closes the gate for three cycles ahead of a pending mode-0 request.
    glog.delete(); gcyc_log.delete();
    arm(0, 2'd2);
    for (int t = 0; t < 5 && glog.size() == 0; t++) step();
    arm(1, 2'd0);
    for (int t = 0; t < 10 && glog.size() < 2; t++) step();
    chk("m2_second_grant", 64'(glog.size()), 64'd2);
    if (gcyc_log.size() == 2) chk("m2_gate_gap", 64'(gcyc_log[1] - gcyc_log[0]), 64'd4);
    drain("m2_drain");

    // Mixed precisions with a back-pressured response port.
    glog.delete();
    for (int t = 0; t < 60; t++) begin
      if (t < 40) for (int i = 0; i < N; i++) if (!req_valid[i]) arm(i, 2'($urandom_range(0, 2)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    drain("mix_drain");
    chk("mix_all_served", 64'(req_valid), 64'd0);

    // Credits: four issues fill the FIFO, the fifth waits for a pop.
    rsp_ready = 1'b0; keep_valid = 1'b1; glog.delete();
    for (int i = 0; i < N; i++) arm(i, 2'd0);
    for (int t = 0; t < 12; t++) step();
    chk("credit_hold", 64'(glog.size()), 64'd4);
    chk("credit_full_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();
    chk("credit_after_pop", 64'(glog.size()), 64'd5);
    req_valid = '0; keep_valid = 1'b0;
    drain("credit_drain");

    // Illegal mode: accepted, flagged, never issued.
    glog.delete();
    arm(2, 2'd3);
    for (int t = 0; t < 5 && glog.size() == 0; t++) step();
    for (int t = 0; t < 4; t++) step();
    chk("m3_granted", 64'(glog.size()), 64'd1);
    chk("m3_err", 64'(err), 64'd1);
    chk("m3_idle", 64'({busy, rsp_valid}), 64'd0);

    // Reset in the middle of traffic discards everything in flight or queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) arm(i, 2'($urandom_range(0, 2)));
    for (int t = 0; t < 6; t++) step();
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1 reset_outs("reset_mid");
    sb.delete(); exp_mv = 1'b0; exp_err = 1'b0;
    @(negedge clk) reset_outs("reset_hold");
    tick();
    @(negedge clk) begin
      req_valid = '0;
      rst_n = 1'b1;
    end
    tick();
    rsp_ready = 1'b1;
    for (int t = 0; t < 20; t++) step();
    chk("post_reset_idle", 64'({rsp_valid, busy, err}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
